// File: rtl/inv_key_expander_if.sv
// Load/stream bundle for the reverse AES key scheduler: key load on one side,
// valid/ready round-key stream on the other.
interface inv_key_expander_if #(
  parameter int N = 8
);
  logic            start;
  logic [32*N-1:0] key_in;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    round_key;
  logic [3:0]      round_idx;
  logic            out_last;

  // Controller side: loads the key and consumes round keys.
  modport master (
    output start, key_in, out_ready,
    input  busy, out_valid, round_key, round_idx, out_last
  );

  // Scheduler side.
  modport slave (
    input  start, key_in, out_ready,
    output busy, out_valid, round_key, round_idx, out_last
  );
endinterface

// File: rtl/inv_key_expander.sv
// Reverse AES key schedule. Starting from the last N words of the expanded
// schedule, regenerates one older word per cycle and streams round keys from
// NR down to 0 for the decryption datapath.
module inv_key_expander #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  inv_key_expander_if.slave bus
);

  localparam int         NR        = N + 6;
  localparam int         LOG_N     = (N == 8) ? 3 : 2;
  localparam logic [5:0] BASE_INIT = 6'(4*NR + 4 - N);
  localparam logic [3:0] LAST_IDX  = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    STEP
  } fsmState;

  fsmState state, nextState;

  logic [31:0]  win [N];   // win[0] = oldest word w[base], win[N-1] = youngest
  logic [31:0]  shWin [N]; // window after one shift
  logic [5:0]   base;
  logic [5:0]   shiftCnt;
  logic [5:0]   nextK;
  logic [127:0] roundKey;
  logic [3:0]   roundIdx;
  logic         outLast;

  logic         loadEn;
  logic         stepEn;

  logic [6:0]   iVal;
  logic         rotSel;
  logic         subSel;
  logic [3:0]   rconIdx;
  logic [31:0]  prevWord;
  logic [31:0]  sbIn;
  logic [31:0]  sbOut;
  logic [31:0]  gOut;
  logic [31:0]  newWord;

  function automatic logic [7:0] rconOf(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Index of the youngest window word and which g() variant it needs.
  assign iVal     = {1'b0, base} + 7'(N - 1);
  assign rotSel   = ((iVal & 7'(N - 1)) == 7'd0);
  assign subSel   = (N == 8) && (iVal[2:0] == 3'd4);
  assign rconIdx  = 4'(iVal >> LOG_N);
  assign prevWord = win[N-2];
  assign sbIn     = rotSel ? {prevWord[23:0], prevWord[31:24]} : prevWord;

  // Single shared SubWord, fed either RotWord(x) or x.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sbOut = '0;
    for (int j = 0; j < 4; j++) begin
      sbOut[8*j +: 8] = SBOX[sbIn[8*j +: 8]];
    end
  end

  // g() selection and the regenerated older word; zero once the schedule is exhausted.
  always_comb begin
    gOut = prevWord;
    if (rotSel) begin
      gOut = sbOut ^ {rconOf(rconIdx), 24'h000000};
    end else if (subSel) begin
      gOut = sbOut;
    end
    newWord = (base == 6'd0) ? 32'h0 : (win[N-1] ^ gOut);
  end

  // Window shifted toward younger words: new word enters at the old end.
  always_comb begin
    shWin[0] = newWord;
    for (int j = 1; j < N; j++) begin
      shWin[j] = win[j-1];
    end
  end

  assign nextK = shiftCnt + 6'd1;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and datapath enables.
  always_comb begin
    nextState = state;
    loadEn    = 1'b0;
    stepEn    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          nextState = EMIT;
          loadEn    = 1'b1;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          nextState = (roundIdx == 4'd0) ? IDLE : STEP;
        end
      end
      STEP: begin
        stepEn = 1'b1;
        if (shiftCnt[1:0] == 2'd3) begin
          nextState = EMIT;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Window, counters and registered round-key outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the window is a small register array, not a RAM, so it can and must be cleared on reset.
      for (int j = 0; j < N; j++) begin
        win[j] <= '0;
      end
      base     <= '0;
      shiftCnt <= '0;
      roundKey <= '0;
      roundIdx <= '0;
      outLast  <= 1'b0;
    end else if (loadEn) begin
      for (int j = 0; j < N; j++) begin
        win[j] <= bus.key_in[32*(N-j)-1 -: 32];
      end
      base     <= BASE_INIT;
      shiftCnt <= '0;
      roundKey <= bus.key_in[127:0];
      roundIdx <= LAST_IDX;
      outLast  <= 1'b0;
    end else if (stepEn) begin
      for (int j = 0; j < N; j++) begin
        win[j] <= shWin[j];
      end
      if (base != 6'd0) begin
        base <= base - 6'd1;
      end
      shiftCnt <= nextK;
      if (shiftCnt[1:0] == 2'd3) begin
        roundKey <= {shWin[N-4], shWin[N-3], shWin[N-2], shWin[N-1]};
        roundIdx <= LAST_IDX - nextK[5:2];
        outLast  <= (nextK[5:2] == LAST_IDX);
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == EMIT);
  assign bus.round_key = roundKey;
  assign bus.round_idx = roundIdx;
  assign bus.out_last  = outLast;

endmodule

// File: tb/tb_inv_key_expander.sv
// Bench for the reverse key scheduler. The reference is a forward AES key
// expansion from an original cipher key (S-box derived from GF(2^8) inverses);
// the DUT is loaded with the last N expanded words and must stream the round
// keys back in decryption order.
module tb_inv_key_expander;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         outReady;
  logic         useEight;
  logic [255:0] keyIn;

  int checks = 0;
  int errors = 0;

  inv_key_expander_if #(.N(4)) bus4();
  inv_key_expander_if #(.N(8)) bus8();

  assign bus4.start     = start & ~useEight;
  assign bus4.key_in    = keyIn[127:0];
  assign bus4.out_ready = outReady;
  assign bus8.start     = start & useEight;
  assign bus8.key_in    = keyIn;
  assign bus8.out_ready = outReady;

  inv_key_expander #(.N(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  inv_key_expander #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  logic         obsValid, obsBusy, obsLast;
  logic [127:0] obsKey;
  logic [3:0]   obsIdx;

  assign obsValid = useEight ? bus8.out_valid : bus4.out_valid;
  assign obsBusy  = useEight ? bus8.busy      : bus4.busy;
  assign obsLast  = useEight ? bus8.out_last  : bus4.out_last;
  assign obsKey   = useEight ? bus8.round_key : bus4.round_key;
  assign obsIdx   = useEight ? bus8.round_idx : bus4.round_idx;

  always #5 clk = ~clk;

  localparam logic [255:0] FIPS128_KEY = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [255:0] FIPS256_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [7:0]   sboxTb [256];
  logic [31:0]  expW   [60];
  logic [127:0] gotKey [15];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gfMul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      end
      sboxTb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWordTb(input logic [31:0] x);
    return {sboxTb[x[31:24]], sboxTb[x[23:16]], sboxTb[x[15:8]], sboxTb[x[7:0]]};
  endfunction

  // Forward AES key expansion of an n-word cipher key into expW.
  task automatic expand(input int n, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) expW[i] = '0;
    for (int i = 0; i < n; i++) expW[i] = key[32*(n-i)-1 -: 32];
    for (int i = n; i < 4*(n+7); i++) begin
      t = expW[i-1];
      if (i % n == 0) begin
        t  = subWordTb({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end else if (n > 6 && i % n == 4) begin
        t = subWordTb(t);
      end
      expW[i] = expW[i-n] ^ t;
    end
  endtask

  function automatic logic [255:0] randWide();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Loads the tail of the expansion and follows the whole stream, checking
  // values, flags and exact cycle spacing. Returns just after the idx-0
  // handshake edge (or after an injected reset).
  task automatic runKey(input int n, input logic [255:0] origKey, input int stallAt,
                        input int stallLen, input int pokeAt, input int resetAt,
                        input bit finalStart);
    int           nr;
    int           waited;
    logic [127:0] expKey;
    logic [127:0] heldKey;
    logic [3:0]   heldIdx;
    nr = n + 6;
    for (int i = 0; i < 15; i++) gotKey[i] = '0;
    expand(n, origKey);
    @(negedge clk);
    useEight = (n == 8);
    keyIn    = '0;
    for (int j = 0; j < n; j++) keyIn[32*(n-j)-1 -: 32] = expW[4*nr+4-n+j];
    start    = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    start = 1'b0;
    keyIn = randWide();
    for (int r = nr; r >= 0; r--) begin
      waited = 0;
      while (obsValid !== 1'b1 && waited < 30) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (waited != 0 || obsValid !== 1'b1) begin
        errors++;
        $display("FAIL key_timing n=%0d round %0d: valid=%b after %0d extra cycles, required valid with 0", n, r, obsValid, waited);
      end
      if (obsValid !== 1'b1) return;
      expKey = {expW[4*r], expW[4*r+1], expW[4*r+2], expW[4*r+3]};
      checks++;
      if (obsIdx !== 4'(r)) begin
        errors++;
        $display("FAIL round_idx n=%0d: got %0d expected %0d", n, obsIdx, r);
      end
      checks++;
      if (obsKey !== expKey) begin
        errors++;
        $display("FAIL round_key n=%0d idx %0d: got %h expected %h", n, r, obsKey, expKey);
      end
      checks++;
      if (obsLast !== (r == 0) || obsBusy !== 1'b1) begin
        errors++;
        $display("FAIL flags n=%0d idx %0d: last=%b busy=%b expected last=%b busy=1", n, r, obsLast, obsBusy, (r == 0));
      end
      gotKey[r] = obsKey;
      if (r == stallAt) begin
        outReady = 1'b0;
        heldKey  = obsKey;
        heldIdx  = obsIdx;
        repeat (stallLen) begin
          @(negedge clk);
          checks++;
          if (obsValid !== 1'b1 || obsKey !== heldKey || obsIdx !== heldIdx) begin
            errors++;
            $display("FAIL backpressure_hold idx %0d: valid=%b idx=%0d key=%h expected valid=1 idx=%0d key=%h", r, obsValid, obsIdx, obsKey, heldIdx, heldKey);
          end
        end
        outReady = 1'b1;
      end
      if (r == 0 && finalStart) begin
        start = 1'b1;
        keyIn = randWide();
      end
      @(posedge clk);
      if (r == 0) return;
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        checks++;
        if (obsValid !== 1'b0 || obsBusy !== 1'b1 || obsIdx !== 4'(r) || obsKey !== expKey) begin
          errors++;
          $display("FAIL step_hold idx %0d cyc %0d: valid=%b busy=%b idx=%0d key=%h expected valid=0 busy=1 idx=%0d key=%h", r, s, obsValid, obsBusy, obsIdx, obsKey, r, expKey);
        end
        if (s == 0 && r == resetAt) begin
          reset = 1'b1;
          @(negedge clk);
          checks++;
          if (obsValid !== 1'b0 || obsBusy !== 1'b0 || obsLast !== 1'b0 || obsKey !== '0 || obsIdx !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b last=%b idx=%0d key=%h expected all zero", obsValid, obsBusy, obsLast, obsIdx, obsKey);
          end
          reset = 1'b0;
          return;
        end
        if (s == 0 && r == pokeAt) begin
          start = 1'b1;
          keyIn = randWide();
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    outReady = 1'b0;
    useEight = 1'b0;
    keyIn    = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus4.busy !== 1'b0 || bus4.out_valid !== 1'b0 || bus4.out_last !== 1'b0 ||
        bus4.round_key !== '0 || bus4.round_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_n4: busy=%b valid=%b last=%b idx=%0d key=%h expected all zero", bus4.busy, bus4.out_valid, bus4.out_last, bus4.round_idx, bus4.round_key);
    end
    checks++;
    if (bus8.busy !== 1'b0 || bus8.out_valid !== 1'b0 || bus8.out_last !== 1'b0 ||
        bus8.round_key !== '0 || bus8.round_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_n8: busy=%b valid=%b last=%b idx=%0d key=%h expected all zero", bus8.busy, bus8.out_valid, bus8.out_last, bus8.round_idx, bus8.round_key);
    end
    reset    = 1'b0;
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b0 || bus8.out_valid !== 1'b0 || bus4.busy !== 1'b0 || bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: valid4=%b valid8=%b busy4=%b busy8=%b expected all 0", bus4.out_valid, bus8.out_valid, bus4.busy, bus8.busy);
    end
  endtask

  task automatic test_fips128();
    runKey(4, FIPS128_KEY, -1, 0, -1, -1, 1'b0);
    checks++;
    if (gotKey[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL fips128_idx10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", gotKey[10]);
    end
    checks++;
    if (gotKey[9] !== 128'hac7766f319fadc2128d12941575c006e) begin
      errors++;
      $display("FAIL fips128_idx9: got %h expected ac7766f319fadc2128d12941575c006e", gotKey[9]);
    end
    checks++;
    if (gotKey[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++;
      $display("FAIL fips128_idx0: got %h expected 2b7e151628aed2a6abf7158809cf4f3c", gotKey[0]);
    end
  endtask

  task automatic test_fips256();
    runKey(8, FIPS256_KEY, -1, 0, -1, -1, 1'b0);
    // Round keys 0 and 1 together are the original 256-bit cipher key.
    checks++;
    if (gotKey[0] !== 128'h603deb1015ca71be2b73aef0857d7781) begin
      errors++;
      $display("FAIL fips256_idx0: got %h expected 603deb1015ca71be2b73aef0857d7781", gotKey[0]);
    end
    checks++;
    if (gotKey[1] !== 128'h1f352c073b6108d72d9810a30914dff4) begin
      errors++;
      $display("FAIL fips256_idx1: got %h expected 1f352c073b6108d72d9810a30914dff4", gotKey[1]);
    end
  endtask

  task automatic test_backpressure();
    runKey(4, FIPS128_KEY, 7, 3, -1, -1, 1'b0);
    checks++;
    if (gotKey[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++;
      $display("FAIL backpressure_idx0: got %h expected 2b7e151628aed2a6abf7158809cf4f3c", gotKey[0]);
    end
  endtask

  task automatic test_start_while_busy();
    runKey(4, FIPS128_KEY, -1, 0, 5, -1, 1'b0);
  endtask

  task automatic test_mid_reset();
    runKey(4, FIPS128_KEY, -1, 0, -1, 4, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (obsValid !== 1'b0 || obsBusy !== 1'b0) begin
        errors++;
        $display("FAIL after_reset_quiet cyc %0d: valid=%b busy=%b expected 0 0", c, obsValid, obsBusy);
      end
    end
    runKey(4, FIPS128_KEY, -1, 0, -1, -1, 1'b0);
    checks++;
    if (gotKey[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || gotKey[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++;
      $display("FAIL restart_after_reset: idx10=%h idx0=%h", gotKey[10], gotKey[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] lastKey;
    // start coinciding with the final handshake must be ignored
    runKey(4, FIPS128_KEY, -1, 0, -1, -1, 1'b1);
    lastKey = {expW[0], expW[1], expW[2], expW[3]};
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (obsBusy !== 1'b0 || obsValid !== 1'b0 || obsIdx !== 4'd0 || obsLast !== 1'b1 || obsKey !== lastKey) begin
      errors++;
      $display("FAIL final_start_ignored: busy=%b valid=%b idx=%0d last=%b key=%h expected 0 0 0 1 %h", obsBusy, obsValid, obsIdx, obsLast, obsKey, lastKey);
    end
    @(negedge clk);
    checks++;
    if (obsBusy !== 1'b0 || obsValid !== 1'b0) begin
      errors++;
      $display("FAIL final_start_idle: busy=%b valid=%b expected 0 0", obsBusy, obsValid);
    end
    // each runKey asserts start the cycle after the previous idx-0 handshake
    runKey(4, {128'h0, randWide()}, -1, 0, -1, -1, 1'b0);
    runKey(4, {128'h0, randWide()}, -1, 0, -1, -1, 1'b0);
    runKey(8, randWide(), -1, 0, -1, -1, 1'b0);
    runKey(8, randWide(), -1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      n = (it % 2 == 0) ? 4 : 8;
      runKey(n, (n == 4) ? {128'h0, randWide()} : randWide(),
             $urandom_range(0, n + 6), $urandom_range(1, 4), -1, -1, 1'b0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    buildSbox();
    test_reset();
    test_fips128();
    test_fips256();
    test_backpressure();
    test_start_while_busy();
    test_mid_reset();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
